// File: rtl/mips_ctrl_defs_pkg.sv
// Shared MIPS control definitions: opcode/funct constants, ALU codes and the
// control bundle carried from decode through write-back.
package mips_ctrl_defs;

   localparam int unsigned OPCODE_WIDTH = 6;
   localparam int unsigned FUNCT_WIDTH  = 6;
   localparam int unsigned ALU_OP_W     = 4;
   localparam int unsigned DEST_W       = 5;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;

   localparam logic [FUNCT_WIDTH-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_WIDTH-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_WIDTH-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_WIDTH-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_WIDTH-1:0] FN_SLT = 6'b101010;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_SLT = 4'b0100
   } alu_op_e;

   typedef struct packed {
      logic                reg_dst;
      logic                alu_src;
      alu_op_e             alu_op;
      logic                branch;
      logic                mem_read;
      logic                mem_write;
      logic                reg_write;
      logic                memto_reg;
      logic [DEST_W-1:0]   dest;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of one MIPS instruction into a control bundle plus an
// illegal flag; unknown encodings come out as a bubble.
module control_decoder
   import mips_ctrl_defs::*;
#(
   parameter int unsigned IWIDTH = 32
) (
   input  logic [IWIDTH-1:0] instr,
   output ctrl_bundle_t      bundle,
   output logic              illegal,
   output logic              reads_rt,
   output logic [DEST_W-1:0] rs,
   output logic [DEST_W-1:0] rt
);

   logic [OPCODE_WIDTH-1:0] opcode;
   logic [FUNCT_WIDTH-1:0]  funct;
   logic [DEST_W-1:0]       rd;
   logic [DEST_W-1:0]       dest;
   logic                    unused_shamt;

   assign opcode       = instr[31:26];
   assign rs           = instr[25:21];
   assign rt           = instr[20:16];
   assign rd           = instr[15:11];
   assign funct        = instr[5:0];
   assign unused_shamt = ^instr[10:6];

   always_comb begin
      bundle   = CTRL_BUBBLE;
      illegal  = 1'b0;
      reads_rt = 1'b0;
      dest     = '0;
      case (opcode)
         OP_RTYPE: begin
            reads_rt         = 1'b1;
            bundle.reg_dst   = 1'b1;
            bundle.reg_write = 1'b1;
            dest             = rd;
            case (funct)
               FN_ADD:  bundle.alu_op = ALU_ADD;
               FN_SUB:  bundle.alu_op = ALU_SUB;
               FN_AND:  bundle.alu_op = ALU_AND;
               FN_OR:   bundle.alu_op = ALU_OR;
               FN_SLT:  bundle.alu_op = ALU_SLT;
               default: illegal       = 1'b1;
            endcase
         end
         OP_LW: begin
            bundle.alu_src   = 1'b1;
            bundle.mem_read  = 1'b1;
            bundle.memto_reg = 1'b1;
            bundle.reg_write = 1'b1;
            dest             = rt;
         end
         OP_SW: begin
            reads_rt          = 1'b1;
            bundle.alu_src    = 1'b1;
            bundle.mem_write  = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            bundle.alu_src   = 1'b1;
            bundle.reg_write = 1'b1;
            dest             = rt;
            if (opcode == OP_ANDI)     bundle.alu_op = ALU_AND;
            else if (opcode == OP_ORI) bundle.alu_op = ALU_OR;
         end
         OP_BEQ: begin
            reads_rt      = 1'b1;
            bundle.alu_op = ALU_SUB;
            bundle.branch = 1'b1;
         end
         default: illegal = 1'b1;
      endcase

      // Writes to $0 are architecturally dropped
      bundle.dest = dest;
      if (dest == '0) bundle.reg_write = 1'b0;
      if (illegal)    bundle = CTRL_BUBBLE;
   end

endmodule

// File: rtl/pipeline_control.sv
// Pipelined MIPS control: decodes the ID-stage instruction, carries the bundle
// through EX/MS/WB registers, detects load-use hazards and flushes branches.
module pipeline_control
   import mips_ctrl_defs::*;
#(
   parameter int unsigned IWIDTH      = 32,
   parameter int unsigned AWIDTH      = 5,
   parameter int unsigned ALUOP_WIDTH = 4
) (
   input  logic                   c_clk,
   input  logic                   c_rst,
   input  logic                   c_i_ce,
   input  logic [IWIDTH-1:0]      c_i_instr,
   input  logic                   c_i_valid,
   input  logic                   c_i_flush,
   output logic                   c_o_stall,
   output logic                   c_o_ex_RegDst,
   output logic                   c_o_ex_ALUSrc,
   output logic [ALUOP_WIDTH-1:0] c_o_ex_alu_op,
   output logic                   c_o_ex_Branch,
   output logic                   c_o_ms_MemRead,
   output logic                   c_o_ms_MemWrite,
   output logic                   c_o_wb_RegWrite,
   output logic                   c_o_wb_MemtoReg,
   output logic [AWIDTH-1:0]      c_o_wb_rd,
   output logic                   c_o_illegal
);

   ctrl_bundle_t      dec_bundle;
   ctrl_bundle_t      ex_next;
   ctrl_bundle_t      ex_q;
   ctrl_bundle_t      ms_q;
   ctrl_bundle_t      wb_q;
   logic              dec_illegal;
   logic              dec_reads_rt;
   logic [DEST_W-1:0] dec_rs;
   logic [DEST_W-1:0] dec_rt;
   logic              stall_c;
   logic              illegal_q;
   logic              unused_wb;

   control_decoder #(.IWIDTH(IWIDTH)) u_decoder (
      .instr    (c_i_instr),
      .bundle   (dec_bundle),
      .illegal  (dec_illegal),
      .reads_rt (dec_reads_rt),
      .rs       (dec_rs),
      .rt       (dec_rt)
   );

   // Load in EX whose destination feeds the decode-stage instruction; flush wins
   always_comb begin
      stall_c = 1'b0;
      if (!c_rst && !c_i_flush && c_i_valid && ex_q.mem_read && (ex_q.dest != '0)) begin
         stall_c = (ex_q.dest == dec_rs) || (dec_reads_rt && (ex_q.dest == dec_rt));
      end
   end

   always_comb begin
      ex_next = dec_bundle;
      if (c_i_flush || stall_c || !c_i_valid || dec_illegal) ex_next = CTRL_BUBBLE;
   end

   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         ex_q      <= CTRL_BUBBLE;
         ms_q      <= CTRL_BUBBLE;
         wb_q      <= CTRL_BUBBLE;
         illegal_q <= 1'b0;
      end else if (c_i_ce) begin
         ex_q      <= ex_next;
         ms_q      <= ex_q;
         wb_q      <= ms_q;
         illegal_q <= c_i_valid && !c_i_flush && !stall_c && dec_illegal;
      end else begin
         illegal_q <= 1'b0;
      end
   end

   assign c_o_stall       = stall_c;
   assign c_o_ex_RegDst   = ex_q.reg_dst;
   assign c_o_ex_ALUSrc   = ex_q.alu_src;
   assign c_o_ex_alu_op   = ALUOP_WIDTH'(ex_q.alu_op);
   assign c_o_ex_Branch   = ex_q.branch;
   assign c_o_ms_MemRead  = ms_q.mem_read;
   assign c_o_ms_MemWrite = ms_q.mem_write;
   assign c_o_wb_RegWrite = wb_q.reg_write;
   assign c_o_wb_MemtoReg = wb_q.memto_reg;
   assign c_o_wb_rd       = AWIDTH'(wb_q.dest);
   assign c_o_illegal     = illegal_q;
   assign unused_wb       = ^wb_q;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Pipelined control unit for the 5-stage MIPS datapath. Decodes the instruction held in the decode stage into a control bundle, then carries that bundle through registers aligned to the execute, memory and write-back stages, so the datapath's control inputs no longer need to be driven by hand. It also detects load-use hazards, raising a one-cycle stall, and turns branch flushes into pipeline bubbles.

## Interface
Parameters:
- IWIDTH, 32, instruction width
- AWIDTH, 5, register-file address width
- ALUOP_WIDTH, 4, ALU operation code width

Ports:
- c_clk  input  1  clock; single clock domain
- c_rst  input  1  synchronous, active-high reset
- c_i_ce  input  1  pipeline advance enable
- c_i_instr  input  IWIDTH  instruction currently in the decode stage
- c_i_valid  input  1  c_i_instr is a real instruction (0 = bubble)
- c_i_flush  input  1  branch taken in execute; kill the decode-stage instruction
- c_o_stall  output  1  load-use hazard; hold PC and the IF/ID register (combinational)
- c_o_ex_RegDst  output  1  execute stage: 1 = rd, 0 = rt
- c_o_ex_ALUSrc  output  1  execute stage: 1 = immediate operand
- c_o_ex_alu_op  output  ALUOP_WIDTH  execute-stage ALU operation
- c_o_ex_Branch  output  1  execute stage holds a beq
- c_o_ms_MemRead  output  1  memory-stage load
- c_o_ms_MemWrite  output  1  memory-stage store
- c_o_wb_RegWrite  output  1  write-back enable
- c_o_wb_MemtoReg  output  1  write-back source: 1 = memory, 0 = ALU
- c_o_wb_rd  output  AWIDTH  write-back destination register
- c_o_illegal  output  1  one-cycle pulse: an unknown opcode or funct was retired into execute

## Operation
- Supported instructions and their decode:
  - R-type (op 000000), funct add 100000, sub 100010, and 100100, or 100101, slt 101010: RegDst=1, RegWrite=1.
  - lw 100011: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, dest=rt.
  - sw 101011: ALUSrc=1, MemWrite=1.
  - addi 001000, andi 001100, ori 001101: ALUSrc=1, RegWrite=1, dest=rt.
  - beq 000100: alu_op=SUB, Branch=1.
- ALU op encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100. lw, sw and addi use ADD.
- Destination $0: RegWrite is forced to 0 when dest == 0.
- Unknown opcode or funct: decoded as a bubble (all controls 0); illegal flag travels with it into execute.
- Load-use hazard: c_o_stall = c_i_valid & EX.MemRead & (EX.dest != 0) & (EX.dest == rs, or EX.dest == rt for instructions that read rt: R-type, sw, beq).
- Register update on each c_clk edge with c_i_ce = 1 and no reset:
  - EX ← bubble if c_i_flush | c_o_stall | !c_i_valid | illegal; otherwise the decoded bundle.
  - MS ← EX, WB ← MS.
- c_i_flush has priority over the stall; when flush is asserted, c_o_stall is forced to 0.
- c_i_ce = 0: all stage registers hold. c_o_stall is still computed. c_o_illegal is 0.

## Timing
- Reset (synchronous, c_rst = 1 at an edge): every stage register becomes a bubble. All outputs 0, including c_o_stall and c_o_wb_rd. Reset overrides ce and flush.
- Latency: instruction in decode at cycle n → EX controls valid in n+1, MS controls in n+2, WB controls in n+3.
- Stall lasts exactly one cycle. The bubble it inserts clears EX.MemRead, so the held instruction issues on the next cycle.
- c_o_illegal is registered and asserts in the cycle the illegal instruction would occupy EX.
- Back-to-back lw followed by a dependent lw: stalls one cycle, same as any other load-use pair.

## Structure
- Shared header `mips_ctrl_defs` holds:
  - opcode and funct constants,
  - ALU op codes,
  - OPCODE_WIDTH and FUNCT_WIDTH,
  - the control-bundle field widths.
- Sub-module `control_decoder`: purely combinational, maps instruction → bundle + illegal.
- The top level holds the EX/MS/WB registers and the hazard logic.

## Test plan
- Reset mid-stream with lw in MS → next cycle all outputs 0, c_o_wb_rd = 0.
- 0x00221820 (add $3,$1,$2), valid → n+1: RegDst=1, alu_op=0000; n+3: RegWrite=1, wb_rd=3, MemtoReg=0.
- 0x8C220000 (lw $2,0($1)) then 0x00441820 (add $3,$2,$4) → stall=1 for one cycle, EX bubble; add reaches WB 4 cycles after decode with wb_rd=3.
- 0xAC220004 (sw) → MS MemWrite=1, RegWrite=0. 0x20050007 (addi $5,$0,7) → ALUSrc=1, wb_rd=5, RegWrite=1.
- 0x10220003 (beq) → ex_Branch=1, alu_op=0001; c_i_flush during the next decode → that slot is a bubble, no stall.
- 0xFC000000 → c_o_illegal pulses at n+1, no writes. ce=0 for 3 cycles → outputs frozen.
